// File: rtl/seg_scroll_display_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared types and helpers for the scrolling 7-segment display driver.
//   SEG_BLANK  : all segments off (active-low)
//   CHAR_BLANK : character code that renders as a blank digit
//   char_t     : 5-bit character code (0x00-0x0F hex glyph, anything else blank)
//   glyph()    : character code -> active-low segments, MSB = a ... LSB = g
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    typedef logic [4:0] char_t;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam char_t      CHAR_BLANK = 5'h1F;

    // Segment order in the returned vector is a,b,c,d,e,f,g from MSB to LSB so
    // that it lands directly on a [0:6] port with bit 0 = a.
    function automatic logic [6:0] glyph(input char_t c);
        logic [6:0] seg;
        case (c)
            5'h00:   seg = 7'b0000001;
            5'h01:   seg = 7'b1001111;
            5'h02:   seg = 7'b0010010;
            5'h03:   seg = 7'b0000110;
            5'h04:   seg = 7'b1001100;
            5'h05:   seg = 7'b0100100;
            5'h06:   seg = 7'b0100000;
            5'h07:   seg = 7'b0001111;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0000100;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b1100000;
            5'h0C:   seg = 7'b0110001;
            5'h0D:   seg = 7'b1000010;
            5'h0E:   seg = 7'b0110000;
            5'h0F:   seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scroll_display_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running clock-enable strobe generator. Counts 0..DIV-1 and raises tick
// for the single cycle in which the count equals DIV-1, then wraps to 0. The
// first strobe after reset is therefore seen on the DIV-th clock edge.
//   CLK100MHZ : system clock
//   RESET     : synchronous, active-high reset (count -> 0)
//   tick      : 1-cycle strobe, period DIV cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic CLK100MHZ,
    input  logic RESET,
    output logic tick
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scroll_display.sv
// -----------------------------------------------------------------------------
// seg_scroll_display
// Scrolling-message driver for a multiplexed common-anode 7-segment bank.
// A message of MSG_LEN characters followed by NUM_DIGITS blanks forms a
// circular stream of PERIOD characters; a window of NUM_DIGITS characters
// starting at pos is shown, leftmost digit first.
//
// Ports:
//   CLK100MHZ : system clock (all timing via clock-enable strobes)
//   RESET     : synchronous, active-high reset
//   msg_data  : MSG_LEN 5-bit char codes, char j at [5j+4:5j]
//   msg_load  : 1-cycle pulse, captures msg_data and restarts at pos 0
//   dir       : 0 = scroll left (pos++), 1 = scroll right (pos--)
//   pause     : 1 = hold pos, scanning continues
//   AN        : active-low digit enables, AN[0] = rightmost digit
//   HEX0      : active-low segments, bit 0 = a ... bit 6 = g
//   pos       : current scroll position
//   DP        : (only with SEG_DP_MARK_EN) active-low, low while the active
//               digit shows stream index 0 (message start marker)
//
// Build option: define SEG_DP_MARK_EN to add the DP output.
// -----------------------------------------------------------------------------
module seg_scroll_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int MSG_LEN     = 4,
    parameter int SCROLL_DIV  = 40000000,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                                     CLK100MHZ,
    input  logic                                     RESET,
    input  logic [5*MSG_LEN-1:0]                     msg_data,
    input  logic                                     msg_load,
    input  logic                                     dir,
    input  logic                                     pause,
    output logic [NUM_DIGITS-1:0]                    AN,
    output logic [0:6]                               HEX0,
    output logic [$clog2(MSG_LEN+NUM_DIGITS)-1:0]    pos
`ifdef SEG_DP_MARK_EN
    ,
    output logic                                     DP
`endif
);

    localparam int PERIOD = MSG_LEN + NUM_DIGITS;
    localparam int PW     = $clog2(PERIOD);
    localparam int IW     = $clog2(PERIOD) + 1;
    localparam int SW     = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] POS_LAST  = PW'(PERIOD - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_DIGITS - 1);

    logic scroll_tick;
    logic refresh_tick;

    tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .tick      (scroll_tick)
    );

    tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .tick      (refresh_tick)
    );

    // ---------------------------------------------------------------- message
    char_t msg_q [MSG_LEN];
    char_t msg_d [MSG_LEN];

    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_msg
        always_comb begin
            msg_d[gi] = msg_load ? char_t'(msg_data[5*gi +: 5]) : msg_q[gi];
        end

        always_ff @(posedge CLK100MHZ) begin
            if (RESET) begin
                msg_q[gi] <= CHAR_BLANK;
            end else begin
                msg_q[gi] <= msg_d[gi];
            end
        end
    end

    // ------------------------------------------------------- position / scan
    logic [PW-1:0]         pos_q,  pos_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic                  upd_q,  upd_d;
    logic [NUM_DIGITS-1:0] an_q,   an_d;
    logic [6:0]            hex_q,  hex_d;

    logic [IW-1:0]         sum;
    logic [IW-1:0]         idx;
    char_t                 cur_char;

    always_comb begin
        // A load wins over a coincident scroll strobe.
        pos_d = pos_q;
        if (msg_load) begin
            pos_d = '0;
        end else if (scroll_tick && !pause) begin
            if (dir) begin
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
            end else begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end
        end

        scan_d = scan_q;
        if (refresh_tick) begin
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        end

        // Outputs are reloaded the cycle after the scan index moves.
        upd_d = refresh_tick;

        // Digit k shows stream[(pos + NUM_DIGITS-1-k) mod PERIOD]. The sum is
        // below 2*PERIOD, so the extra index bit keeps it from overflowing.
        sum = IW'(pos_q) + IW'(NUM_DIGITS - 1) - IW'(scan_q);
        idx = sum % IW'(PERIOD);

        cur_char = CHAR_BLANK;
        for (int j = 0; j < MSG_LEN; j++) begin
            if (idx == IW'(j)) begin
                cur_char = msg_q[j];
            end
        end

        an_d  = an_q;
        hex_d = hex_q;
        if (upd_q) begin
            an_d  = ~(NUM_DIGITS'(1) << scan_q);
            hex_d = glyph(cur_char);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            pos_q  <= '0;
            scan_q <= '0;
            upd_q  <= 1'b0;
            an_q   <= '1;
            hex_q  <= SEG_BLANK;
        end else begin
            pos_q  <= pos_d;
            scan_q <= scan_d;
            upd_q  <= upd_d;
            an_q   <= an_d;
            hex_q  <= hex_d;
        end
    end

    assign AN   = an_q;
    assign HEX0 = hex_q;
    assign pos  = pos_q;

`ifdef SEG_DP_MARK_EN
    logic dp_q, dp_d;

    always_comb begin
        dp_d = dp_q;
        if (upd_q) begin
            dp_d = (idx != '0);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign DP = dp_q;
`endif

endmodule

// File: tb/tb_seg_scroll_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scroll_display
// Scoreboard bench: the stimulus process pushes expected display states tagged
// with the clock cycle at which they must be visible; a monitor on the falling
// edge pops each entry when its cycle arrives and compares it with the DUT.
// Configuration: NUM_DIGITS=4, MSG_LEN=4, SCROLL_DIV=8, REFRESH_DIV=2.
// -----------------------------------------------------------------------------
module tb_seg_scroll_display;

    localparam int R = 3;   // cycle count of the last reset edge

    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GD = 7'b1000010;
    localparam logic [6:0] GE = 7'b0110000;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] msg_data;
    logic        msg_load;
    logic        dir;
    logic        pause;
    logic [3:0]  an_o;
    logic [0:6]  hex_o;
    logic [2:0]  pos_o;
`ifdef SEG_DP_MARK_EN
    logic        dp_o;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        bit         full;
        logic [3:0] an;
        logic [6:0] hex;
        int         pos;
        bit         dp;
    } exp_t;

    exp_t sb[$];

    seg_scroll_display #(
        .NUM_DIGITS  (4),
        .MSG_LEN     (4),
        .SCROLL_DIV  (8),
        .REFRESH_DIV (2)
    ) dut (
        .CLK100MHZ (clk),
        .RESET     (rst),
        .msg_data  (msg_data),
        .msg_load  (msg_load),
        .dir       (dir),
        .pause     (pause),
        .AN        (an_o),
        .HEX0      (hex_o),
        .pos       (pos_o)
`ifdef SEG_DP_MARK_EN
        ,
        .DP        (dp_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int off, input bit full, input logic [3:0] an,
                        input logic [6:0] hex, input int p, input bit dp);
        exp_t e;
        e.cyc  = R + off;
        e.full = full;
        e.an   = an;
        e.hex  = hex;
        e.pos  = p;
        e.dp   = dp;
        sb.push_back(e);
    endtask

    task automatic push_pos(input int off, input int p);
        push(off, 1'b0, 4'hF, GB, p, 1'b1);
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0b expected=%0b", name, c, act, exp);
        end
    endtask

    // Monitor: compares each scoreboard entry on the falling edge of its cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL late_entry cyc=%0d got=cycle %0d expected=cycle %0d",
                         cyc, cyc, e.cyc);
            end else begin
                $display("chk cyc=%0d AN=%b HEX0=%b pos=%0d", cyc, an_o, hex_o, pos_o);
                check("pos", cyc, 32'(pos_o), 32'(e.pos));
                if (e.full) begin
                    check("AN", cyc, 32'(an_o), 32'(e.an));
                    check("HEX0", cyc, 32'(hex_o), 32'(e.hex));
`ifdef SEG_DP_MARK_EN
                    check("DP", cyc, 32'(dp_o), 32'(e.dp));
`endif
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        msg_data = '0;
        msg_load = 1'b0;
        dir      = 1'b0;
        pause    = 1'b1;

        // Reset state, first refresh strobe at R+2, first AN change at R+3.
        push(0, 1, 4'b1111, GB, 0, 1);
        push(2, 1, 4'b1111, GB, 0, 1);
        push(3, 1, 4'b1101, GB, 0, 1);
        at_cycle(R);
        rst = 1'b0;

        // Paused load of "1,0,d,E"; digit k shows char 3-k.
        at_cycle(R + 3);
        msg_data = {5'h0E, 5'h0D, 5'h00, 5'h01};
        msg_load = 1'b1;
        push(5,  1, 4'b1011, G0, 0, 1);
        push(6,  1, 4'b1011, G0, 0, 1);
        push(7,  1, 4'b0111, G1, 0, 0);
        push_pos(8, 0);
        push(9,  1, 4'b1110, GE, 0, 1);
        push(11, 1, 4'b1101, GD, 0, 1);
        push(13, 1, 4'b1011, G0, 0, 1);
        push(15, 1, 4'b0111, G1, 0, 0);
        at_cycle(R + 4);
        msg_load = 1'b0;

        // Scroll left, one step every 8 cycles starting at R+24.
        at_cycle(R + 16);
        pause = 1'b0;
        push_pos(24, 1);
        push_pos(32, 2);
        push(49, 1, 4'b1110, GB, 4, 1);
        push(51, 1, 4'b1101, GB, 4, 1);
        push(53, 1, 4'b1011, GB, 4, 1);
        push(55, 1, 4'b0111, GB, 4, 1);
        push(57, 1, 4'b1110, G1, 5, 0);
        push(59, 1, 4'b1101, GB, 5, 1);
        push(61, 1, 4'b1011, GB, 5, 1);
        push(63, 1, 4'b0111, GB, 5, 1);
        push(73, 1, 4'b1110, GD, 7, 1);
        push(75, 1, 4'b1101, G0, 7, 1);
        push(77, 1, 4'b1011, G1, 7, 0);
        push(79, 1, 4'b0111, GB, 7, 1);
        push_pos(80, 0);

        // Scroll right from 0 wraps to 7.
        at_cycle(R + 80);
        dir = 1'b1;
        push_pos(88, 7);
        push_pos(96, 6);
        at_cycle(R + 96);
        dir = 1'b0;

        // Load on a scroll strobe edge: pos 0, not 7. Char 0 = 0x15 is blank.
        at_cycle(R + 103);
        msg_data = {5'h07, 5'h05, 5'h0A, 5'h15};
        msg_load = 1'b1;
        push_pos(104, 0);
        push(105, 1, 4'b1110, G7, 0, 1);
        push(107, 1, 4'b1101, G5, 0, 1);
        push(109, 1, 4'b1011, GA, 0, 1);
        push(111, 1, 4'b0111, GB, 0, 0);
        push_pos(112, 1);
        push_pos(113, 1);
        at_cycle(R + 104);
        msg_load = 1'b0;

        // Reset mid-scroll together with a load: reset wins, message blanked.
        at_cycle(R + 114);
        rst      = 1'b1;
        msg_load = 1'b1;
        push(115, 1, 4'b1111, GB, 0, 1);
        push(117, 1, 4'b1111, GB, 0, 1);
        push(118, 1, 4'b1101, GB, 0, 1);
        at_cycle(R + 115);
        rst      = 1'b0;
        msg_load = 1'b0;

        at_cycle(R + 125);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL unchecked_entry cyc=%0d got=none expected=cycle %0d", cyc, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
